// File: rtl/lc3_alu_cc.sv
// LC-3 execute-stage ALU with the processor status state (NZP, PRIV, PRIO) and
// the registered branch-enable flag consumed by the control FSM.
module lc3_alu_cc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      IR,
    input  logic [WIDTH-1:0] SR1OUT,
    input  logic [WIDTH-1:0] SR2OUT,
    input  logic [1:0]       ALUK,
    input  logic [WIDTH-1:0] main_bus,
    input  logic             LD_CC,
    input  logic             LD_BEN,
    input  logic             LD_PSR,
    input  logic             LD_PRIV,
    input  logic             PRIV_VAL,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic [15:0]      PSR_OUT,
    output logic             N,
    output logic             Z,
    output logic             P,
    output logic             BEN
);

    logic [WIDTH-1:0] opb;
    logic [2:0]       nzp_q, nzp_d;
    logic [2:0]       prio_q, prio_d;
    logic             priv_q, priv_d;
    logic             ben_q, ben_d;
    logic             unused_bits;

    assign unused_bits = ^{IR[15:12], IR[8:6], main_bus[14:11], main_bus[7:3]};

    function automatic logic [2:0] cc_from(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1])
            return 3'b100;
        else if (v == '0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    always_comb begin
        opb = IR[5] ? {{(WIDTH-5){IR[4]}}, IR[4:0]} : SR2OUT;
        case (ALUK)
            2'b00:   ALU_OUT = SR1OUT + opb;
            2'b01:   ALU_OUT = SR1OUT & opb;
            2'b10:   ALU_OUT = ~SR1OUT;
            default: ALU_OUT = SR1OUT;
        endcase
    end

    always_comb begin
        nzp_d  = nzp_q;
        prio_d = prio_q;
        priv_d = priv_q;
        // BEN always samples the codes held before this edge
        ben_d  = LD_BEN ? |(IR[11:9] & nzp_q) : ben_q;
        if (LD_PSR) begin
            priv_d = main_bus[15];
            prio_d = main_bus[10:8];
            case (main_bus[2:0])
                3'b100, 3'b010, 3'b001: nzp_d = main_bus[2:0];
                default:                nzp_d = 3'b010;
            endcase
        end else begin
            if (LD_CC)
                nzp_d = cc_from(main_bus);
            if (LD_PRIV)
                priv_d = PRIV_VAL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nzp_q  <= 3'b010;
            prio_q <= 3'b000;
            priv_q <= 1'b0;
            ben_q  <= 1'b0;
        end else begin
            nzp_q  <= nzp_d;
            prio_q <= prio_d;
            priv_q <= priv_d;
            ben_q  <= ben_d;
        end
    end

    assign N       = nzp_q[2];
    assign Z       = nzp_q[1];
    assign P       = nzp_q[0];
    assign BEN     = ben_q;
    assign PSR_OUT = {priv_q, 4'b0000, prio_q, 5'b00000, nzp_q};

endmodule

// File: tb/tb_lc3_alu_cc.sv
// Directed and randomized bench for lc3_alu_cc against an arithmetic reference model.
module tb_lc3_alu_cc;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] IR, SR1OUT, SR2OUT, main_bus;
    logic [1:0]  ALUK;
    logic        LD_CC, LD_BEN, LD_PSR, LD_PRIV, PRIV_VAL;
    logic [15:0] ALU_OUT, PSR_OUT;
    logic        N, Z, P, BEN;

    int total = 0;
    int bad   = 0;

    // reference state
    logic [2:0] m_nzp;
    logic       m_priv;
    logic [2:0] m_prio;
    logic       m_ben;

    always #5 clk = ~clk;

    lc3_alu_cc #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .IR(IR), .SR1OUT(SR1OUT), .SR2OUT(SR2OUT),
        .ALUK(ALUK), .main_bus(main_bus), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
        .LD_PSR(LD_PSR), .LD_PRIV(LD_PRIV), .PRIV_VAL(PRIV_VAL),
        .ALU_OUT(ALU_OUT), .PSR_OUT(PSR_OUT), .N(N), .Z(Z), .P(P), .BEN(BEN)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] alu_ref(input logic [15:0] ir, input logic [15:0] a,
                                            input logic [15:0] b2, input logic [1:0] k);
        int imm;
        int b;
        if (ir[5]) begin
            imm = int'(ir[4:0]);
            if (imm >= 16) imm = imm - 32;
            b = imm;
        end else begin
            b = int'(b2);
        end
        case (k)
            2'd0:    return 16'((int'(a) + b) & 32'hFFFF);
            2'd1:    return a & 16'(b);
            2'd2:    return 16'(65535 - int'(a));
            default: return a;
        endcase
    endfunction

    function automatic logic [2:0] cc_ref(input logic [15:0] v);
        int s;
        s = int'(v);
        if (s >= 32768) s = s - 65536;
        if (s < 0)  return 3'b100;
        if (s == 0) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [15:0] psr_ref();
        return 16'(int'(m_priv) * 32768 + int'(m_prio) * 256 + int'(m_nzp));
    endfunction

    task automatic model_reset();
        m_nzp = 3'b010; m_priv = 1'b0; m_prio = 3'd0; m_ben = 1'b0;
    endtask

    task automatic model_edge();
        logic [2:0] old_nzp;
        old_nzp = m_nzp;
        if (LD_BEN) m_ben = ((IR[11:9] & old_nzp) != 3'b000);
        if (LD_PSR) begin
            m_priv = main_bus[15];
            m_prio = main_bus[10:8];
            if (main_bus[2:0] == 3'b100 || main_bus[2:0] == 3'b010 || main_bus[2:0] == 3'b001)
                m_nzp = main_bus[2:0];
            else
                m_nzp = 3'b010;
        end else begin
            if (LD_CC)   m_nzp = cc_ref(main_bus);
            if (LD_PRIV) m_priv = PRIV_VAL;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, " psr"}, PSR_OUT, psr_ref());
        check({tag, " nzp"}, {13'd0, N, Z, P}, {13'd0, m_nzp});
        check({tag, " ben"}, {15'd0, BEN}, {15'd0, m_ben});
    endtask

    task automatic do_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic loads_off();
        LD_CC = 0; LD_BEN = 0; LD_PSR = 0; LD_PRIV = 0; PRIV_VAL = 0;
    endtask

    initial begin
        rst = 1'b1;
        IR = 16'h0; SR1OUT = 16'h0; SR2OUT = 16'h0; main_bus = 16'h0; ALUK = 2'd0;
        loads_off();
        model_reset();
        #2;
        check("reset psr", PSR_OUT, 16'h0002);
        check_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // ALU immediate forms
        IR = 16'h1023; SR1OUT = 16'hFFFF; ALUK = 2'd0; #1;
        check("add imm +3", ALU_OUT, 16'h0002);
        IR = 16'h103F; SR1OUT = 16'h0000; #1;
        check("add imm -1", ALU_OUT, 16'hFFFF);

        // ALUK sweep, register operand
        IR = 16'h1000; SR1OUT = 16'hF0F0; SR2OUT = 16'h0FF0;
        ALUK = 2'd0; #1; check("sweep add",  ALU_OUT, 16'h00E0);
        ALUK = 2'd1; #1; check("sweep and",  ALU_OUT, 16'h00F0);
        ALUK = 2'd2; #1; check("sweep not",  ALU_OUT, 16'h0F0F);
        ALUK = 2'd3; #1; check("sweep pass", ALU_OUT, 16'hF0F0);

        // CC loads
        LD_CC = 1; main_bus = 16'h8000; do_edge();
        check("cc neg", {13'd0, N, Z, P}, 16'h0004);
        main_bus = 16'h0000; do_edge();
        check("cc zero", {13'd0, N, Z, P}, 16'h0002);
        main_bus = 16'h0001; do_edge();
        check("cc pos", {13'd0, N, Z, P}, 16'h0001);

        // BEN sees codes from before the same-edge CC load
        IR = 16'h0200; LD_BEN = 1; LD_CC = 1; main_bus = 16'h0000; do_edge();
        check("ben old p", {15'd0, BEN}, 16'h0001);
        check("ben cc new", {13'd0, N, Z, P}, 16'h0002);
        LD_CC = 0; do_edge();
        check("ben clear", {15'd0, BEN}, 16'h0000);
        LD_BEN = 0; do_edge();
        check_state("hold");

        // PSR load priority and NZP correction
        LD_PSR = 1; LD_CC = 1; LD_PRIV = 1; PRIV_VAL = 0; main_bus = 16'h8704; do_edge();
        check("psr load", PSR_OUT, 16'h8704);
        LD_CC = 0; LD_PRIV = 0; main_bus = 16'h0007; do_edge();
        check("psr fix nzp", PSR_OUT, 16'h0002);

        // PRIV load alone
        loads_off(); LD_PRIV = 1; PRIV_VAL = 1; do_edge();
        check("priv load", PSR_OUT, 16'h8002);

        // asynchronous reset mid-cycle, dominating a pending CC load
        loads_off(); LD_PSR = 1; LD_BEN = 1; IR = 16'h0E00; main_bus = 16'h8501; do_edge();
        check_state("pre-reset");
        loads_off(); LD_CC = 1; main_bus = 16'h8000;
        #2 rst = 1'b1; #1;
        model_reset();
        check("async psr", PSR_OUT, 16'h0002);
        check_state("async");
        @(posedge clk); #1;
        check("reset held psr", PSR_OUT, 16'h0002);
        check_state("reset held");
        @(negedge clk); rst = 1'b0;
        do_edge();
        check("post reset cc", PSR_OUT, 16'h0004);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            IR       = 16'($urandom);
            SR1OUT   = 16'($urandom);
            SR2OUT   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            ALUK     = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       main_bus = 16'h0000;
                1:       main_bus = 16'h8000 | 16'($urandom);
                default: main_bus = 16'($urandom);
            endcase
            LD_CC    = ($urandom_range(0, 1) == 1);
            LD_BEN   = ($urandom_range(0, 1) == 1);
            LD_PSR   = ($urandom_range(0, 4) == 0);
            LD_PRIV  = ($urandom_range(0, 3) == 0);
            PRIV_VAL = ($urandom_range(0, 1) == 1);
            #1;
            check("rand alu", ALU_OUT, alu_ref(IR, SR1OUT, SR2OUT, ALUK));
            do_edge();
            check_state("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
